// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the two-lane PHY transmit link controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, packet-owner enum, the fixed line words, and a
// helper that turns a one-hot grant vector into an owner value.
package phy_tx_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_TRAIN    = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_TLP  = 2'd1,
        OWN_DLLP = 2'd2
    } owner_e;

    // Requester indices used for the two-bit grant / accept vectors.
    localparam int REQ_TLP  = 0;
    localparam int REQ_DLLP = 1;

    localparam logic [31:0] TS_WORD   = 32'hBC4A4A4A;
    localparam logic [31:0] SKP_WORD  = 32'h1C1C1C1C;
    localparam logic [31:0] IDLE_WORD = 32'h00000000;

    // One-hot grant to owner; DLLP bit is checked first but the arbiter
    // never raises both bits together.
    function automatic owner_e owner_of(input logic [1:0] gnt);
        if (gnt[REQ_DLLP]) begin
            return OWN_DLLP;
        end else if (gnt[REQ_TLP]) begin
            return OWN_TLP;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-way round-robin arbiter with packet lock for the TLP and DLLP requesters.
// Latency: grant is combinational; owner and round-robin pointer update on the clock edge.
// Backpressure: grant only while en_i is high; a locked owner keeps its grant until it delivers last.
//
// Ports:
//   clk_i, rst_ni     - word-rate clock, asynchronous active-low reset
//   clear_i           - drops any packet lock (link disabled)
//   en_i              - arbitration allowed this cycle
//   req_vld_i/last_i  - per-requester valid and end-of-packet (bit0 TLP, bit1 DLLP)
//   accept_i          - per-requester handshake (grant & valid) from the parent
//   gnt_o             - one-hot grant, used directly as the requester ready
//   owner_o           - requester currently holding the packet lock
module tx_rr_arbiter
    import phy_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [1:0] req_vld_i,
    input  logic [1:0] req_last_i,
    input  logic [1:0] accept_i,
    output logic [1:0] gnt_o,
    output owner_e     owner_o
);

    owner_e owner_q, owner_d;
    // 0: TLP wins the next tie, 1: DLLP wins the next tie.
    logic   rr_dllp_q, rr_dllp_d;

    logic   tie;
    logic   acc_any;
    logic   acc_last;

    assign tie      = req_vld_i[REQ_TLP] && req_vld_i[REQ_DLLP];
    assign acc_any  = |accept_i;
    assign acc_last = |(accept_i & req_last_i);
    assign owner_o  = owner_q;

    // Grant. A locked owner is granted whether or not it is currently
    // valid, so the other requester cannot slip into the middle of a packet.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (owner_q)
                OWN_TLP:  gnt_o = 2'b01;
                OWN_DLLP: gnt_o = 2'b10;
                default: begin
                    if (tie) begin
                        gnt_o = rr_dllp_q ? 2'b10 : 2'b01;
                    end else begin
                        gnt_o = req_vld_i;
                    end
                end
            endcase
        end
    end

    always_comb begin
        owner_d   = owner_q;
        rr_dllp_d = rr_dllp_q;
        if (clear_i) begin
            owner_d = OWN_NONE;
        end else if (owner_q != OWN_NONE) begin
            if (acc_last) begin
                owner_d = OWN_NONE;
            end
        end else if (acc_any) begin
            // Single-word packets never take the lock.
            if (!acc_last) begin
                owner_d = owner_of(accept_i);
            end
            // The loser of this tie is favoured next time.
            if (tie) begin
                rr_dllp_d = accept_i[REQ_TLP];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q   <= OWN_NONE;
            rr_dllp_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            rr_dllp_q <= rr_dllp_d;
        end
    end

endmodule

// File: rtl/phy_tx_ctrl.sv
// Transmit link controller: disable / training / active sequencing and TLP+DLLP sharing of the PHY tx path.
// Latency: 1 cycle from an accepted requester word to tx_data/tx_valid.
// Backpressure: tlp_ready/dllp_ready combinational, only in ACTIVE with link_en high and no SKP due at a boundary.
//
// Ports:
//   clk_2f, reset          - word-rate clock, asynchronous active-low reset
//   link_en                - link enable; low forces DISABLED and truncates any packet in flight
//   tlp_data/valid/last    - TLP requester, tlp_ready back
//   dllp_data/valid/last   - DLLP requester, dllp_ready back
//   tx_data, tx_valid      - registered word to the PHY transmit datapath
//   link_up                - registered, high while ACTIVE
//
// Build option: define PHY_TX_SKP_EN to add periodic SKP insertion at packet
// boundaries every SKP_INTERVAL active cycles. Without it SKP_INTERVAL is unused.
module phy_tx_ctrl
    import phy_tx_pkg::*;
#(
    parameter int TS_COUNT     = 16,
    parameter int SKP_INTERVAL = 64
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        link_en,
    input  logic [31:0] tlp_data,
    input  logic        tlp_valid,
    input  logic        tlp_last,
    output logic        tlp_ready,
    input  logic [31:0] dllp_data,
    input  logic        dllp_valid,
    input  logic        dllp_last,
    output logic        dllp_ready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    output logic        link_up
);

    localparam int TSW = $clog2(TS_COUNT + 1);
    localparam logic [TSW-1:0] TS_LAST = TSW'(TS_COUNT - 1);

    state_e          state_q;
    logic [31:0]     tx_data_q;
    logic            tx_valid_q;
    logic            link_up_q;
    logic [TSW-1:0]  ts_cnt_q;

    owner_e          owner;
    logic [1:0]      gnt;
    logic [1:0]      accept;
    logic [1:0]      req_vld;
    logic [1:0]      req_last;
    logic            arb_en;
    logic            skp_block;
    logic [31:0]     fwd_dat;

`ifdef PHY_TX_SKP_EN
    localparam int SKW = $clog2(SKP_INTERVAL + 1);
    localparam logic [SKW-1:0] SKP_MAX = SKW'(SKP_INTERVAL);
    localparam logic [SKW-1:0] SKP_PRE = SKW'(SKP_INTERVAL - 1);

    logic [SKW-1:0]  skp_cnt_q;
    logic            skp_pend_q;

    // A due SKP only goes out between packets; while it waits for that
    // boundary with no owner, it takes the slot and both readies stay low.
    assign skp_block = skp_pend_q && (owner == OWN_NONE);
`else
    logic            unused_skp_cfg;

    assign unused_skp_cfg = (SKP_INTERVAL >= 2);
    assign skp_block      = 1'b0;
`endif

    assign req_vld  = {dllp_valid, tlp_valid};
    assign req_last = {dllp_last, tlp_last};
    assign arb_en   = (state_q == ST_ACTIVE) && link_en && !skp_block;
    assign accept   = gnt & req_vld;
    assign fwd_dat  = accept[REQ_DLLP] ? dllp_data : tlp_data;

    tx_rr_arbiter u_arb (
        .clk_i      (clk_2f),
        .rst_ni     (reset),
        .clear_i    (!link_en),
        .en_i       (arb_en),
        .req_vld_i  (req_vld),
        .req_last_i (req_last),
        .accept_i   (accept),
        .gnt_o      (gnt),
        .owner_o    (owner)
    );

    assign tlp_ready  = gnt[REQ_TLP];
    assign dllp_ready = gnt[REQ_DLLP];
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign link_up    = link_up_q;

    // Link FSM with registered line outputs. The line idles by default and
    // each state overrides the word it drives this cycle.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_DISABLED;
            tx_data_q  <= IDLE_WORD;
            tx_valid_q <= 1'b0;
            link_up_q  <= 1'b0;
            ts_cnt_q   <= '0;
`ifdef PHY_TX_SKP_EN
            skp_cnt_q  <= '0;
            skp_pend_q <= 1'b0;
`endif
        end else begin
            tx_data_q  <= IDLE_WORD;
            tx_valid_q <= 1'b0;
            if (!link_en) begin
                state_q   <= ST_DISABLED;
                link_up_q <= 1'b0;
                ts_cnt_q  <= '0;
`ifdef PHY_TX_SKP_EN
                skp_cnt_q  <= '0;
                skp_pend_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_DISABLED: begin
                        state_q  <= ST_TRAIN;
                        ts_cnt_q <= '0;
                    end
                    ST_TRAIN: begin
                        tx_data_q  <= TS_WORD;
                        tx_valid_q <= 1'b1;
                        if (ts_cnt_q == TS_LAST) begin
                            state_q   <= ST_ACTIVE;
                            link_up_q <= 1'b1;
                            ts_cnt_q  <= '0;
                        end else begin
                            ts_cnt_q <= ts_cnt_q + 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        link_up_q <= 1'b1;
                        if (skp_block) begin
                            tx_data_q  <= SKP_WORD;
                            tx_valid_q <= 1'b1;
                        end else if (|accept) begin
                            tx_data_q  <= fwd_dat;
                            tx_valid_q <= 1'b1;
                        end
`ifdef PHY_TX_SKP_EN
                        // Saturating interval counter; pending is raised on the
                        // edge where the count reaches the interval.
                        if (skp_block) begin
                            skp_cnt_q  <= '0;
                            skp_pend_q <= 1'b0;
                        end else begin
                            if (skp_cnt_q != SKP_MAX) begin
                                skp_cnt_q <= skp_cnt_q + 1'b1;
                            end
                            if (skp_cnt_q >= SKP_PRE) begin
                                skp_pend_q <= 1'b1;
                            end
                        end
`endif
                    end
                    default: begin
                        state_q   <= ST_DISABLED;
                        link_up_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Self-checking bench for phy_tx_ctrl: directed vectors, multi-cycle corner cases, random traffic vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_phy_tx_ctrl;
    import phy_tx_pkg::*;

    localparam int TS_N  = 16;
    localparam int SKP_N = 8;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic        link_en;
    logic [31:0] tlp_data, dllp_data;
    logic        tlp_valid, tlp_last, dllp_valid, dllp_last;
    logic        tlp_ready, dllp_ready;
    logic [31:0] tx_data;
    logic        tx_valid, link_up;

    phy_tx_ctrl #(.TS_COUNT(TS_N), .SKP_INTERVAL(SKP_N)) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .link_en    (link_en),
        .tlp_data   (tlp_data),
        .tlp_valid  (tlp_valid),
        .tlp_last   (tlp_last),
        .tlp_ready  (tlp_ready),
        .dllp_data  (dllp_data),
        .dllp_valid (dllp_valid),
        .dllp_last  (dllp_last),
        .dllp_ready (dllp_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .link_up    (link_up)
    );

    always #5 clk_2f = ~clk_2f;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: link phase, words of training sent, active cycles
    // since last SKP, which requester is mid-packet, and who wins the next tie.
`ifdef PHY_TX_SKP_EN
    localparam bit SKP_ON = 1'b1;
`else
    localparam bit SKP_ON = 1'b0;
`endif
    int   m_phase;     // 0 disabled, 1 training, 2 active
    int   m_ts;
    int   m_skp;
    bit   m_due;
    int   m_src;       // -1 none, 0 TLP, 1 DLLP
    int   m_tie;       // requester favoured on the next tie
    logic s_tr, s_dr;

    task automatic model_reset();
        m_phase = 0; m_ts = 0; m_skp = 0; m_due = 0; m_src = -1; m_tie = 0;
    endtask

    // One clock: readies checked before the edge, line outputs after it.
    task automatic cycle();
        int          win;
        bit          acc, lst;
        logic        exp_v;
        logic [31:0] exp_d;
        @(negedge clk_2f);
        s_tr = tlp_ready;
        s_dr = dllp_ready;
        win = -1;
        if (m_phase == 2 && link_en) begin
            if (SKP_ON && m_due && m_src < 0) win = -1;
            else if (m_src >= 0)              win = m_src;
            else if (tlp_valid && dllp_valid) win = m_tie;
            else if (tlp_valid)               win = 0;
            else if (dllp_valid)              win = 1;
        end
        chk("tlp_ready", s_tr, 32'(win == 0));
        chk("dllp_ready", s_dr, 32'(win == 1));
        exp_v = 1'b0;
        exp_d = IDLE_WORD;
        if (!link_en) begin
            m_phase = 0; m_ts = 0; m_skp = 0; m_due = 0; m_src = -1;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            exp_v = 1'b1;
            exp_d = TS_WORD;
            m_ts++;
            if (m_ts == TS_N) begin
                m_phase = 2;
                m_ts = 0;
            end
        end else begin
            if (SKP_ON && m_due && m_src < 0) begin
                exp_v = 1'b1;
                exp_d = SKP_WORD;
                m_skp = 0;
                m_due = 0;
            end else begin
                acc = (win == 0 && tlp_valid) || (win == 1 && dllp_valid);
                if (acc) begin
                    exp_v = 1'b1;
                    exp_d = (win == 0) ? tlp_data : dllp_data;
                    lst   = (win == 0) ? tlp_last : dllp_last;
                    if (m_src < 0 && tlp_valid && dllp_valid) m_tie = 1 - win;
                    m_src = lst ? -1 : win;
                end
                if (SKP_ON) begin
                    if (m_skp < SKP_N) m_skp++;
                    if (m_skp == SKP_N) m_due = 1;
                end
            end
        end
        @(posedge clk_2f);
        #1;
        chk("tx_valid", tx_valid, exp_v);
        chk("tx_data", tx_data, exp_d);
        chk("link_up", link_up, 32'(m_phase == 2));
    endtask

    task automatic idle_inputs();
        tlp_valid = 0; tlp_last = 0; tlp_data = '0;
        dllp_valid = 0; dllp_last = 0; dllp_data = '0;
    endtask

    typedef struct {
        logic        tv, tl;
        logic [31:0] td;
        logic        dv, dl;
        logic [31:0] dd;
        logic        etr, edr, ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ts_seen, gap;
        bit early, found;
        int skp_in;

        tbl[0]  = '{1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, 32'hDDDD0001, 1'b1, 1'b0, 1'b1, 32'h11111111};
        tbl[1]  = '{1'b1, 1'b0, 32'h22222222, 1'b1, 1'b1, 32'hDDDD0001, 1'b1, 1'b0, 1'b1, 32'h22222222};
        tbl[2]  = '{1'b1, 1'b1, 32'h33333333, 1'b1, 1'b1, 32'hDDDD0001, 1'b1, 1'b0, 1'b1, 32'h33333333};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDDDD0001, 1'b0, 1'b1, 1'b1, 32'hDDDD0001};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'hA0000001, 1'b1, 1'b1, 32'hB0000001, 1'b0, 1'b1, 1'b1, 32'hB0000001};
        tbl[6]  = '{1'b1, 1'b1, 32'hA0000002, 1'b1, 1'b1, 32'hB0000002, 1'b1, 1'b0, 1'b1, 32'hA0000002};
        tbl[7]  = '{1'b1, 1'b1, 32'hA0000003, 1'b1, 1'b1, 32'hB0000003, 1'b0, 1'b1, 1'b1, 32'hB0000003};
        tbl[8]  = '{1'b1, 1'b1, 32'hA0000004, 1'b1, 1'b1, 32'hB0000004, 1'b1, 1'b0, 1'b1, 32'hA0000004};
        tbl[9]  = '{1'b1, 1'b1, 32'hC0000001, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC0000001};
        tbl[10] = '{1'b1, 1'b1, 32'hC0000002, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC0000002};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hD0000001, 1'b0, 1'b1, 1'b1, 32'hD0000001};
        tbl[13] = '{1'b1, 1'b1, 32'hE0000001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 32'hE0000002, 1'b1, 1'b1, 32'hD0000002, 1'b0, 1'b1, 1'b1, 32'hD0000002};
        tbl[15] = '{1'b1, 1'b1, 32'hE0000003, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hE0000003};

        // Reset state
        reset = 0;
        link_en = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_2f);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, IDLE_WORD);
        chk("rst_link_up", link_up, 0);
        chk("rst_tlp_ready", tlp_ready, 0);
        chk("rst_dllp_ready", dllp_ready, 0);
        reset = 1;
        cycle();

        // Training: exactly TS_N TS words, then link_up
        link_en = 1;
        ts_seen = 0;
        early = 0;
        for (int i = 0; i < TS_N + 1; i++) begin
            cycle();
            if (tx_valid && tx_data == TS_WORD) ts_seen++;
            if (link_up && ts_seen < TS_N) early = 1;
        end
        chk("train_ts_words", ts_seen, TS_N);
        chk("train_link_up", link_up, 1);
        chk("train_link_up_early", early, 0);
        cycle();

`ifndef PHY_TX_SKP_EN
        // Directed arbitration vectors
        for (int i = 0; i < 16; i++) begin
            tlp_valid = tbl[i].tv; tlp_last = tbl[i].tl; tlp_data = tbl[i].td;
            dllp_valid = tbl[i].dv; dllp_last = tbl[i].dl; dllp_data = tbl[i].dd;
            cycle();
            chk($sformatf("vec%0d_tlp_ready", i), s_tr, tbl[i].etr);
            chk($sformatf("vec%0d_dllp_ready", i), s_dr, tbl[i].edr);
            chk($sformatf("vec%0d_tx_valid", i), tx_valid, tbl[i].ev);
            chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].ed);
        end
        idle_inputs();
        cycle();
`endif

        // link_en dropped on word 2 of a 5-word packet
        for (int w = 0; w < 5; w++) begin
            tlp_valid = 1;
            tlp_last = (w == 4);
            tlp_data = 32'hE5000000 + w;
            if (w == 1) link_en = 0;
            cycle();
            if (w == 1) begin
                chk("drop_tlp_ready", s_tr, 0);
                chk("drop_tx_valid", tx_valid, 0);
                chk("drop_link_up", link_up, 0);
                break;
            end
        end
        cycle();

        // Re-enable: all TS words replayed before any data
        link_en = 1;
        tlp_valid = 1;
        tlp_last = 1;
        tlp_data = 32'h12345678;
        ts_seen = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (tx_valid && tx_data == TS_WORD) ts_seen++;
            else if (tx_valid) begin
                found = 1;
                break;
            end
        end
        chk("retrain_ts_words", ts_seen, TS_N);
        chk("retrain_data_after", found, 1);
        idle_inputs();

        // Asynchronous reset mid-training
        link_en = 0;
        cycle();
        link_en = 1;
        repeat (5) cycle();
        chk("pre_areset_tx_valid", tx_valid, 1);
        #1 reset = 0;
        #1;
        chk("areset_tx_valid", tx_valid, 0);
        chk("areset_tx_data", tx_data, IDLE_WORD);
        chk("areset_link_up", link_up, 0);
        link_en = 0;
        model_reset();
        #1 reset = 1;
        cycle();

`ifdef PHY_TX_SKP_EN
        // SKP held off for a long packet, emitted once right after it
        link_en = 1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (link_up) begin
                found = 1;
                break;
            end
        end
        chk("skp_link_up", found, 1);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (tx_valid && tx_data == SKP_WORD) begin
                found = 1;
                break;
            end
        end
        chk("skp_first_seen", found, 1);
        skp_in = 0;
        for (int w = 0; w < 20; w++) begin
            tlp_valid = 1;
            tlp_last = (w == 19);
            tlp_data = 32'hF0000000 + w;
            cycle();
            if (tx_data == SKP_WORD) skp_in++;
        end
        chk("skp_inside_packet", skp_in, 0);
        idle_inputs();
        cycle();
        chk("skp_after_packet", tx_data, SKP_WORD);
        gap = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            gap++;
            if (tx_valid && tx_data == SKP_WORD) begin
                found = 1;
                break;
            end
        end
        chk("skp_restart_found", found, 1);
        chk("skp_restart_gap", gap, SKP_N + 1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            link_en    = ($urandom_range(0, 299) != 0);
            tlp_valid  = ($urandom_range(0, 2) != 0);
            tlp_last   = ($urandom_range(0, 3) == 0);
            tlp_data   = $urandom;
            dllp_valid = ($urandom_range(0, 2) != 0);
            dllp_last  = ($urandom_range(0, 2) == 0);
            dllp_data  = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
